// File: rtl/serial_work_dispatch_if.sv
// rtl/serial_work_dispatch_if.sv - work/nonce/transmitter/receiver signal bundle for serial_work_dispatch
interface serial_work_dispatch_if;
  // work source side
  logic         load;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic         busy;
  logic         done;
  // byte transmitter side
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  // byte receiver side
  logic         rx_data_ready;
  logic [7:0]   rx_data;
  // nonce sink side
  logic [31:0]  nonce;
  logic         nonce_valid;

  // the dispatcher itself
  modport slave (
    input  load, midstate, data2, tx_busy, rx_data_ready, rx_data,
    output busy, done, tx_start, tx_data, nonce, nonce_valid
  );

  // whatever drives the dispatcher: work source, UART pair, nonce sink
  modport master (
    output load, midstate, data2, tx_busy, rx_data_ready, rx_data,
    input  busy, done, tx_start, tx_data, nonce, nonce_valid
  );
endinterface

// File: rtl/serial_work_dispatch.sv
// rtl/serial_work_dispatch.sv - serializes 512-bit work packets to bytes and deframes returned nonce words
module serial_work_dispatch #(
  parameter int WORK_BYTES  = 64,
  parameter int NONCE_BYTES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int RX_TIMEOUT  = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  serial_work_dispatch_if.slave bus
);

  localparam int SHIFT_W = 8 * WORK_BYTES;
  localparam int CNT_W   = $clog2(WORK_BYTES + 1);
  localparam int GAP_W   = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int RC_W    = $clog2(NONCE_BYTES + 1);
  localparam int TO_W    = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_START    = 3'd2,
    ST_GAP      = 3'd3,
    ST_DRAIN    = 3'd4
  } tx_state_t;

  // ---------------------------------------------------------------- TX side
  tx_state_t          state;
  logic [SHIFT_W-1:0] shift_reg;
  logic [CNT_W-1:0]   byte_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               busy_q;
  logic               done_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;

  // Byte serializer: tx_start is raised on entry to START so it is high for
  // exactly the START cycle; GAP masks the transmitter's late busy assertion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.load) begin
            shift_reg <= {bus.midstate, bus.data2};
            byte_cnt  <= '0;
            busy_q    <= 1'b1;
            state     <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= shift_reg[SHIFT_W-1 -: 8];
            state      <= ST_START;
          end
        end
        ST_START: begin
          shift_reg <= {shift_reg[SHIFT_W-9:0], 8'h00};
          byte_cnt  <= byte_cnt + CNT_W'(1);
          gap_cnt   <= GAP_W'(GAP_CYCLES);
          state     <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt > GAP_W'(1)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else begin
            gap_cnt <= '0;
            if (byte_cnt < CNT_W'(WORK_BYTES)) begin
              state <= ST_WAIT_RDY;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.tx_busy) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

  // ---------------------------------------------------------------- RX side
  logic [31:0]     rx_shift;
  logic [RC_W-1:0] rx_cnt;
  logic [TO_W-1:0] timeout_cnt;
  logic [31:0]     nonce_q;
  logic            nonce_valid_q;
  logic            rx_expire;

  // A partial word has sat idle for RX_TIMEOUT cycles and is dropped this cycle.
  assign rx_expire = (rx_cnt != '0) && (timeout_cnt == TO_W'(RX_TIMEOUT));

  // Nonce deframer: MSB byte first; expiry has priority so a byte landing on
  // the expiry cycle starts a fresh word instead of extending the stale one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift      <= '0;
      rx_cnt        <= '0;
      timeout_cnt   <= '0;
      nonce_q       <= '0;
      nonce_valid_q <= 1'b0;
    end else begin
      nonce_valid_q <= 1'b0;
      if (rx_expire) begin
        timeout_cnt <= '0;
        if (bus.rx_data_ready) begin
          rx_shift <= {rx_shift[23:0], bus.rx_data};
          rx_cnt   <= RC_W'(1);
        end else begin
          rx_cnt <= '0;
        end
      end else if (bus.rx_data_ready) begin
        timeout_cnt <= '0;
        rx_shift    <= {rx_shift[23:0], bus.rx_data};
        if (rx_cnt == RC_W'(NONCE_BYTES - 1)) begin
          nonce_q       <= {rx_shift[23:0], bus.rx_data};
          nonce_valid_q <= 1'b1;
          rx_cnt        <= '0;
        end else begin
          rx_cnt <= rx_cnt + RC_W'(1);
        end
      end else if (rx_cnt != '0) begin
        timeout_cnt <= timeout_cnt + TO_W'(1);
      end
    end
  end

  assign bus.nonce       = nonce_q;
  assign bus.nonce_valid = nonce_valid_q;

endmodule

// File: tb/tb_serial_work_dispatch.sv
// tb/tb_serial_work_dispatch.sv - scoreboard bench for serial_work_dispatch
module tb_serial_work_dispatch;

  localparam int RX_TO = 16;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } nonce_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_work_dispatch_if bus();

  serial_work_dispatch #(.RX_TIMEOUT(RX_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tx_seen  = 0;
  int done_cnt = 0;
  int nv_cnt   = 0;
  int tx_cnt   = 0;

  logic [7:0] exp_tx[$];
  nonce_exp_t exp_nonce[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // transmitter model: busy rises the cycle after tx_start and lasts 10 cycles
  always @(posedge clk) begin
    if (bus.tx_start) tx_cnt <= 10;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_busy = (tx_cnt != 0);

  // monitor: pops expectations whenever the DUT presents a byte, done or nonce
  always @(negedge clk) begin
    if (bus.tx_start) begin
      tx_seen++;
      check("tx_start_expected", exp_tx.size() != 0, 1);
      if (exp_tx.size() != 0) check("tx_byte", bus.tx_data, exp_tx.pop_front());
      check("busy_during_tx", bus.busy, 1);
    end
    if (bus.done) begin
      done_cnt++;
      check("done_after_tx_idle", bus.tx_busy, 0);
      check("done_all_bytes_sent", exp_tx.size(), 0);
    end
    if (bus.nonce_valid) begin
      nv_cnt++;
      check("nonce_valid_expected", exp_nonce.size() != 0, 1);
      if (exp_nonce.size() != 0) begin
        nonce_exp_t e;
        e = exp_nonce.pop_front();
        check("nonce_value", bus.nonce, e.val);
        check("nonce_valid_timing", cyc, e.cyc + 1);
      end
    end
  end

  function automatic logic [511:0] mk_pkt(input logic [7:0] base);
    logic [511:0] p;
    for (int i = 0; i < 64; i++) p[511-8*i -: 8] = base + 8'(i);
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_load(input logic [511:0] pkt, input bit expect_sent);
    bus.midstate = pkt[511:256];
    bus.data2    = pkt[255:0];
    bus.load     = 1'b1;
    if (expect_sent) begin
      for (int i = 0; i < 64; i++) exp_tx.push_back(pkt[511-8*i -: 8]);
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_seen < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("wait_tx_count_reached", tx_seen >= n, 1);
    @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("wait_done_reached", done_cnt >= n, 1);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input logic [31:0] word);
    bus.rx_data       = b;
    bus.rx_data_ready = 1'b1;
    if (last) begin
      nonce_exp_t e;
      e.val = word;
      e.cyc = cyc;
      exp_nonce.push_back(e);
    end
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], i == 3, w);
      tick(gap);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus.load          = 1'b0;
    bus.midstate      = '0;
    bus.data2         = '0;
    bus.rx_data_ready = 1'b0;
    bus.rx_data       = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("reset_busy",        bus.busy, 0);
    check("reset_done",        bus.done, 0);
    check("reset_tx_start",    bus.tx_start, 0);
    check("reset_tx_data",     bus.tx_data, 0);
    check("reset_nonce",       bus.nonce, 0);
    check("reset_nonce_valid", bus.nonce_valid, 0);

    // full packet, bytes 0x01..0x40
    send_load(mk_pkt(8'h01), 1'b1);
    check("busy_after_load", bus.busy, 1);
    wait_done(1, 3000);
    check("pkt1_byte_count", tx_seen, 64);
    check("pkt1_busy_low", bus.busy, 0);
    check("pkt1_queue_empty", exp_tx.size(), 0);

    // load while busy is ignored
    send_load(mk_pkt(8'h41), 1'b1);
    wait_tx(74, 500);
    send_load(mk_pkt(8'hC0), 1'b0);
    wait_done(2, 3000);
    check("pkt2_byte_count", tx_seen, 128);
    check("pkt2_done_count", done_cnt, 2);
    tick(30);
    check("pkt2_no_extra_tx", tx_seen, 128);

    // reset mid-packet abandons it
    send_load(mk_pkt(8'h20), 1'b1);
    wait_tx(158, 600);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_tx.delete();
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_tx_start", bus.tx_start, 0);
    tick(40);
    check("rst_mid_no_more_tx", tx_seen, 158);
    check("rst_mid_no_done", done_cnt, 2);
    send_load(mk_pkt(8'h80), 1'b1);
    wait_done(3, 3000);
    check("pkt4_byte_count", tx_seen, 222);

    // nonce deframing
    send_word(32'hDEADBEEF, 1);
    tick(3);
    check("nonce_deadbeef", bus.nonce, 32'hDEADBEEF);
    check("nonce_pulse_count1", nv_cnt, 1);

    // partial word discarded after idle timeout
    send_byte(8'h11, 1'b0, 32'h0);
    send_byte(8'h22, 1'b0, 32'h0);
    tick(20);
    check("timeout_no_pulse", nv_cnt, 1);
    check("timeout_nonce_held", bus.nonce, 32'hDEADBEEF);
    send_word(32'hAABBCCDD, 0);
    tick(3);
    check("nonce_aabbccdd", bus.nonce, 32'hAABBCCDD);
    check("nonce_pulse_count2", nv_cnt, 2);

    // TX and RX concurrently
    send_load(mk_pkt(8'h90), 1'b1);
    fork
      wait_done(4, 3000);
      begin
        tick(30);
        send_word(32'h12345678, 2);
        tick(200);
        send_word(32'hCAFEF00D, 0);
        tick(300);
        send_word(32'h0BADC0DE, 3);
      end
    join
    tick(5);
    check("conc_byte_count", tx_seen, 286);
    check("conc_nonce_pulses", nv_cnt, 5);
    check("conc_last_nonce", bus.nonce, 32'h0BADC0DE);
    check("final_tx_queue_empty", exp_tx.size(), 0);
    check("final_nonce_queue_empty", exp_nonce.size(), 0);
    check("final_busy_low", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_work_dispatch.md
Name: serial_work_dispatch

Overview:
Cluster-master end of the board-to-board serial work link. Serializes one 512-bit work packet (256-bit midstate, then 256-bit data2) into 64 bytes for a byte-level UART transmitter. Deframes the 4-byte golden-nonce words returned by a worker board into 32-bit words. Sits between the master's work source/nonce sink and one async_transmitter/async_receiver pair.

Parameters:
WORK_BYTES, 64, bytes per work packet (fixed by the 512-bit payload; not meant to be changed)
NONCE_BYTES, 4, bytes per returned nonce word
GAP_CYCLES, 2, cycles after tx_start during which tx_busy is ignored (covers transmitter busy latency)
RX_TIMEOUT, 1000000, idle cycles after which a partial nonce word is discarded

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
load  in  1  request to send the packet present on midstate/data2
midstate  in  256  work midstate, sampled on accepted load
data2  in  256  work data tail, sampled on accepted load
busy  out  1  high from the cycle after an accepted load until packet completion
done  out  1  one-cycle pulse when the last byte's transmission has finished
tx_start  out  1  one-cycle start strobe to the transmitter
tx_data  out  8  byte to transmit, stable from tx_start until the next tx_start
tx_busy  in  1  transmitter busy
rx_data_ready  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
nonce  out  32  last complete nonce word, held until the next word
nonce_valid  out  1  one-cycle pulse, nonce updated

Behaviour:
- Reset (sync, high): busy=0, done=0, tx_start=0, tx_data=0, nonce=0, nonce_valid=0, byte and gap counters=0, RX byte count=0, timeout counter=0, TX FSM=IDLE. Reset wins over every simultaneous input. Reset mid-packet abandons the packet; no done.
- TX FSM states:
  - IDLE: load accepted only here. Latch shift={midstate,data2}, byte count=0, go to WAIT_RDY. busy=1 the next cycle.
  - WAIT_RDY: when tx_busy=0, go to START.
  - START: drive tx_start=1 for exactly this cycle with tx_data=shift[511:504]. Shift the register left 8 bits, increment the byte count, load the gap counter = GAP_CYCLES, go to GAP.
  - GAP: decrement the gap counter. At 0, go to WAIT_RDY if byte count < WORK_BYTES, otherwise go to DRAIN.
  - DRAIN: when tx_busy=0, pulse done=1 for one cycle, busy=0 from that same cycle, return to IDLE.
- load while busy=1 is ignored. No queuing, and the latched data is not altered.
- Byte order: midstate[255:248] first, data2[7:0] last. This matches the worker receive side, which shifts bytes into the LSB.
- Minimum per-byte time is 2+GAP_CYCLES cycles plus the transmitter's busy time.
- RX deframer:
  - On rx_data_ready: rxshift={rxshift[23:0],rx_data}, increment the count, clear the timeout counter.
  - On the NONCE_BYTES-th byte: nonce is updated with the full word, nonce_valid=1 on the following cycle, count returns to 0. The first byte received is nonce[31:24].
  - While count≠0 and no byte arrives, the timeout counter increments. When it reaches RX_TIMEOUT, count=0 and the partial word is discarded; nonce is unchanged and no pulse.
  - A byte arriving in the same cycle as timeout expiry counts as the first byte of a new word.
- TX and RX are fully independent and operate concurrently.

Test Plan:
- After reset, check every output is 0. Load midstate=256'h00..01_02…20 pattern, data2 incrementing bytes, with a transmitter model (busy for 10 cycles, rising 1 cycle after start) -> exactly 64 tx_start pulses in order midstate[255:248]…data2[7:0], one done pulse after the final busy falls, busy=0 after that.
- load pulsed again at byte 10 with different data -> ignored; the remaining 54 bytes are still from the original packet; one done.
- Assert reset at byte 30 -> tx_start stays low, busy=0, no done. A subsequent load sends all 64 bytes of the new packet.
- RX bytes 0xDE,0xAD,0xBE,0xEF -> nonce=32'hDEADBEEF, nonce_valid is a single pulse one cycle after the 4th strobe.
- With RX_TIMEOUT=16: send 0x11,0x22, wait 20 idle cycles, then send 0xAA,0xBB,0xCC,0xDD -> no pulse for the partial word; nonce=32'hAABBCCDD.
- Send a full packet while 3 nonce words are received concurrently -> packet bytes are correct, and 3 nonce_valid pulses arrive with correct values.
